ipdc_feeder: RTL and testbench

- Upstream sequencer for the image-processing display controller (ipdc). Accepts operation commands and a 24-bit RGB pixel stream, then drives ipdc's op/in handshake.
- Buffers a full 8x8 image so the load phase is delivered as 64 contiguous pixels, regardless of gaps at the source.
- Waits for ipdc to finish each operation and reports completion with a pulse.

---
 rtl/ipdc_feeder_if.sv | 30 +++
 rtl/ipdc_feeder.sv | 132 +++++++++++++
 tb/tb_ipdc_feeder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ipdc_feeder_if.sv
// ipdc_feeder_if: command, source-pixel and ipdc-side handshakes of the feeder.
// Signal names are given from the feeder's point of view (i_* into it, o_* out).
interface ipdc_feeder_if #(
    parameter int DATA_W = 24
);
    logic              i_cmd_valid;
    logic [2:0]        i_cmd_mode;
    logic              o_cmd_ready;
    logic              i_pix_valid;
    logic [DATA_W-1:0] i_pix_data;
    logic              o_pix_ready;
    logic              i_ipdc_ready;
    logic              o_op_valid;
    logic [2:0]        o_op_mode;
    logic              o_in_valid;
    logic [DATA_W-1:0] o_in_data;
    logic              o_done;

    // Environment side: issues commands, supplies pixels, reports ipdc status.
    modport master (
        output i_cmd_valid, i_cmd_mode, i_pix_valid, i_pix_data, i_ipdc_ready,
        input  o_cmd_ready, o_pix_ready, o_op_valid, o_op_mode, o_in_valid, o_in_data, o_done
    );

    // Feeder side.
    modport slave (
        input  i_cmd_valid, i_cmd_mode, i_pix_valid, i_pix_data, i_ipdc_ready,
        output o_cmd_ready, o_pix_ready, o_op_valid, o_op_mode, o_in_valid, o_in_data, o_done
    );
endinterface

// File: rtl/ipdc_feeder.sv
// ipdc_feeder: sequences commands into ipdc. A load command first buffers a
// whole image from a gappy source, then issues the op and streams the image
// back-to-back; every command finishes by waiting for ipdc to go idle again.
module ipdc_feeder #(
    parameter int         IMG_PIX   = 64,
    parameter int         DATA_W    = 24,
    parameter int         HOLDOFF   = 2,
    parameter logic [2:0] LOAD_MODE = 3'd0
) (
    input logic          i_clk,
    input logic          i_rst,
    ipdc_feeder_if.slave bus
);
    localparam int               CNT_W    = $clog2(IMG_PIX);
    localparam int               HO_W     = $clog2(HOLDOFF + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_PIX - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF);

    // DONE is the cycle o_done is high; it keeps o_cmd_ready low for that cycle
    // so the next command is taken the cycle after the completion pulse.
    typedef enum logic [2:0] {IDLE, FILL, ISSUE, STREAM, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HO_W-1:0]   ho_q, ho_d;
    logic              op_valid_q, op_valid_d;
    logic [2:0]        op_mode_q, op_mode_d;
    logic              in_valid_q, in_valid_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              done_q, done_d;
    logic              pix_we;

    // Image store; never reset, contents are only read after a full fill.
    logic [DATA_W-1:0] pix_buf [IMG_PIX];

    // Ready flags come straight from the state register; held low in reset.
    assign bus.o_cmd_ready = (state_q == IDLE) && !i_rst;
    assign bus.o_pix_ready = (state_q == FILL);
    assign bus.o_op_valid  = op_valid_q;
    assign bus.o_op_mode   = op_mode_q;
    assign bus.o_in_valid  = in_valid_q;
    assign bus.o_in_data   = in_data_q;
    assign bus.o_done      = done_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        ho_d       = ho_q;
        op_valid_d = 1'b0;
        op_mode_d  = '0;
        in_valid_d = 1'b0;
        in_data_d  = '0;
        done_d     = 1'b0;
        pix_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    mode_d  = bus.i_cmd_mode;
                    cnt_d   = '0;
                    state_d = (bus.i_cmd_mode == LOAD_MODE) ? FILL : ISSUE;
                end
            end
            FILL: begin
                if (bus.i_pix_valid) begin
                    pix_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.i_ipdc_ready) begin
                    op_valid_d = 1'b1;
                    op_mode_d  = mode_q;
                    cnt_d      = '0;
                    ho_d       = '0;
                    state_d    = (mode_q == LOAD_MODE) ? STREAM : BUSY;
                end
            end
            STREAM: begin
                in_valid_d = 1'b1;
                in_data_d  = pix_buf[cnt_q];
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = BUSY;
            end
            BUSY: begin
                // ipdc may still report ready right after the op; ignore it
                // until the holdoff has elapsed.
                if (ho_q != HO_LAST) begin
                    ho_d = ho_q + 1'b1;
                end else if (bus.i_ipdc_ready) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            cnt_q      <= '0;
            ho_q       <= '0;
            op_valid_q <= 1'b0;
            op_mode_q  <= '0;
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            ho_q       <= ho_d;
            op_valid_q <= op_valid_d;
            op_mode_q  <= op_mode_d;
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
            done_q     <= done_d;
        end
    end

    // Image buffer write during FILL.
    always_ff @(posedge i_clk) begin
        if (pix_we) pix_buf[cnt_q] <= bus.i_pix_data;
    end
endmodule

// File: tb/tb_ipdc_feeder.sv
// tb_ipdc_feeder: directed stimulus with a queue scoreboard. Stimulus pushes
// expected op/pixel/done events stamped with their expected cycle; a negedge
// monitor pops and compares whenever the feeder presents one.
module tb_ipdc_feeder;
    localparam int DW = 24;

    typedef struct {
        logic [DW-1:0] val;
        int            cyc;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t op_q[$];
    exp_t pix_q[$];
    exp_t done_q[$];

    ipdc_feeder_if #(.DATA_W(DW)) bus ();

    ipdc_feeder #(.IMG_PIX(64), .DATA_W(DW), .HOLDOFF(2), .LOAD_MODE(3'd0)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: output seen with nothing expected (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [DW-1:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        return e;
    endfunction

    // Scoreboard monitor.
    always @(negedge i_clk) begin
        exp_t e;
        if (bus.o_op_valid) begin
            if (op_q.size() == 0) unexpected("op_pulse");
            else begin
                e = op_q.pop_front();
                chk("op_mode", 32'(bus.o_op_mode), 32'(e.val));
                chk("op_cycle", cyc, e.cyc);
            end
        end else chk("op_mode_zero", 32'(bus.o_op_mode), 0);
        if (bus.o_in_valid) begin
            if (pix_q.size() == 0) unexpected("in_valid");
            else begin
                e = pix_q.pop_front();
                chk("in_data", 32'(bus.o_in_data), 32'(e.val));
                chk("in_cycle", cyc, e.cyc);
            end
        end else chk("in_data_zero", 32'(bus.o_in_data), 0);
        if (bus.o_done) begin
            if (done_q.size() == 0) unexpected("done");
            else begin
                e = done_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Non-load command. Ready is low for hold_issue cycles after acceptance,
    // and low for hold_busy cycles starting at the op pulse.
    task automatic do_op(input logic [2:0] m, input int hold_issue, input int hold_busy,
                         input bit stray);
        int c, t_op, t_done;
        tick();
        c = cyc;
        t_op   = c + 2 + hold_issue;
        t_done = t_op + 1 + ((hold_busy > 2) ? hold_busy : 2);
        op_q.push_back(mk(DW'(m), t_op));
        done_q.push_back(mk('0, t_done));
        bus.i_cmd_valid  = 1'b1;
        bus.i_cmd_mode   = m;
        bus.i_ipdc_ready = 1'b0;
        bus.i_pix_valid  = stray;
        bus.i_pix_data   = 24'hDEAD00;
        if (stray) chk("stray_pix_ready_idle", 32'(bus.o_pix_ready), 0);
        while (cyc < t_done + 1) begin
            tick();
            bus.i_cmd_valid  = 1'b0;
            bus.i_ipdc_ready = (cyc >= c + 1 + hold_issue) &&
                               !(cyc >= t_op && cyc < t_op + hold_busy);
            if (stray) chk("stray_pix_ready", 32'(bus.o_pix_ready), 0);
        end
        bus.i_pix_valid  = 1'b0;
        bus.i_ipdc_ready = 1'b1;
        chk("cmd_ready_after_op", 32'(bus.o_cmd_ready), 1);
    endtask

    // Load command: pixel k = base+k, optionally with one-cycle gaps, optional
    // stray pixel in the command cycle, optional reset at stream pixel 30.
    task automatic do_load(input logic [DW-1:0] base, input bit gaps, input bit stray,
                           input bit abort);
        int c, last, t_op;
        tick();
        c = cyc;
        bus.i_cmd_valid  = 1'b1;
        bus.i_cmd_mode   = 3'd0;
        bus.i_pix_valid  = stray;
        bus.i_pix_data   = 24'hBADBAD;
        bus.i_ipdc_ready = 1'b1;
        if (stray) chk("stray_pix_ready_cmd", 32'(bus.o_pix_ready), 0);
        last = gaps ? c + 127 : c + 64;
        t_op = last + 2;
        op_q.push_back(mk('0, t_op));
        for (int k = 0; k < 64; k++) pix_q.push_back(mk(base + DW'(k), t_op + 1 + k));
        if (!abort) done_q.push_back(mk('0, t_op + 67));
        for (int k = 0; k < 64; k++) begin
            tick();
            bus.i_cmd_valid = 1'b0;
            bus.i_pix_valid = 1'b1;
            bus.i_pix_data  = base + DW'(k);
            if (k == 0 || k == 63) chk("fill_pix_ready", 32'(bus.o_pix_ready), 1);
            if (gaps) begin
                tick();
                bus.i_pix_valid = 1'b0;
                bus.i_pix_data  = '0;
            end
        end
        if (!gaps) begin
            tick();
            bus.i_pix_valid = 1'b0;
            bus.i_pix_data  = '0;
        end
        chk("issue_pix_ready", 32'(bus.o_pix_ready), 0);
        if (abort) begin
            while (cyc < t_op + 31) tick();
            #1;
            i_rst = 1'b1;
            #1;
            chk("rst_mid_in_valid", 32'(bus.o_in_valid), 0);
            chk("rst_mid_in_data", 32'(bus.o_in_data), 0);
            chk("rst_mid_op_valid", 32'(bus.o_op_valid), 0);
            chk("rst_mid_done", 32'(bus.o_done), 0);
            chk("rst_mid_cmd_ready", 32'(bus.o_cmd_ready), 0);
            op_q.delete();
            pix_q.delete();
            done_q.delete();
            tick();
            tick();
            i_rst = 1'b0;
            #1;
            chk("cmd_ready_after_mid_rst", 32'(bus.o_cmd_ready), 1);
        end else begin
            while (cyc < t_op + 68) tick();
            chk("cmd_ready_after_load", 32'(bus.o_cmd_ready), 1);
        end
    endtask

    // Two commands with cmd_valid held high throughout.
    task automatic do_b2b();
        int c;
        tick();
        c = cyc;
        op_q.push_back(mk(24'd2, c + 2));
        done_q.push_back(mk('0, c + 5));
        op_q.push_back(mk(24'd4, c + 8));
        done_q.push_back(mk('0, c + 11));
        bus.i_cmd_valid  = 1'b1;
        bus.i_cmd_mode   = 3'd2;
        bus.i_ipdc_ready = 1'b1;
        tick();
        bus.i_cmd_mode = 3'd4;
        while (cyc < c + 5) tick();
        chk("b2b_cmd_ready_at_done", 32'(bus.o_cmd_ready), 0);
        tick();
        chk("b2b_cmd_ready_after_done", 32'(bus.o_cmd_ready), 1);
        tick();
        bus.i_cmd_valid = 1'b0;
        while (cyc < c + 12) tick();
    endtask

    initial begin
        bus.i_cmd_valid  = 1'b0;
        bus.i_cmd_mode   = '0;
        bus.i_pix_valid  = 1'b0;
        bus.i_pix_data   = '0;
        bus.i_ipdc_ready = 1'b1;
        #2;
        chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 0);
        chk("rst_pix_ready", 32'(bus.o_pix_ready), 0);
        chk("rst_op_valid", 32'(bus.o_op_valid), 0);
        chk("rst_in_valid", 32'(bus.o_in_valid), 0);
        chk("rst_done", 32'(bus.o_done), 0);
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", 32'(bus.o_cmd_ready), 1);

        do_load(24'h000000, 1'b1, 1'b0, 1'b0);  // load with gaps
        do_op(3'd3, 10, 0, 1'b0);               // blocked issue
        do_op(3'd1, 0, 20, 1'b0);               // busy completion
        do_b2b();                               // back-to-back modes 2, 4
        do_op(3'd5, 0, 0, 1'b1);                // stray pixels in IDLE/BUSY
        do_load(24'hA50000, 1'b0, 1'b1, 1'b0);  // load after stray pixels
        do_load(24'h100000, 1'b0, 1'b0, 1'b1);  // reset at stream pixel 30
        do_load(24'hC30040, 1'b1, 1'b0, 1'b0);  // fresh load after reset

        repeat (5) tick();
        chk("op_q_empty", 32'(op_q.size()), 0);
        chk("pix_q_empty", 32'(pix_q.size()), 0);
        chk("done_q_empty", 32'(done_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
